// File: rtl/sig_ram_ctrl_pkg.sv
// Shared types and defaults for the signature RAM controller.
package sig_pkg;

    localparam int unsigned SIG_ADDR_W = 17;
    localparam int unsigned SIG_DEPTH  = 100000;
    localparam int unsigned SIG_RD_LAT = 1;

    localparam logic MODE_RECORD  = 1'b0;
    localparam logic MODE_COMPARE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECORD  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } sig_state_e;

endpackage

// File: rtl/sig_ram_ctrl_if.sv
// Counter-stream, RAM-port and status bundle of the signature RAM controller.
// SIG_RAM_CTRL_FAIL_LOG_EN adds the first-failure address/valid signals.
interface sig_ram_ctrl_if
    import sig_pkg::*;
#(
    parameter int unsigned ADDR_W = SIG_ADDR_W
);

    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_en;
    logic              sig_bit;
    logic              ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_d;
    logic              ram_wren;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] mis_cnt;
`ifdef SIG_RAM_CTRL_FAIL_LOG_EN
    logic [ADDR_W-1:0] fail_addr;
    logic              fail_vld;
`endif

    modport master (
        output start, mode, cnt_addr, cnt_en, sig_bit, ram_q,
`ifdef SIG_RAM_CTRL_FAIL_LOG_EN
        input  fail_addr, fail_vld,
`endif
        input  ram_addr, ram_d, ram_wren, busy, done, pass, mis_cnt
    );

    modport slave (
        input  start, mode, cnt_addr, cnt_en, sig_bit, ram_q,
`ifdef SIG_RAM_CTRL_FAIL_LOG_EN
        output fail_addr, fail_vld,
`endif
        output ram_addr, ram_d, ram_wren, busy, done, pass, mis_cnt
    );

endinterface

// File: rtl/sig_ram_ctrl_align_pipe.sv
// Fixed-length delay line for the {valid, bit, addr} bundle so the live bit
// lines up with RAM read data during COMPARE.
module sig_align_pipe #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic              i_bit,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_vld,
    output logic              o_bit,
    output logic [ADDR_W-1:0] o_addr
);

    localparam int unsigned BUNDLE_W = ADDR_W + 2;

    logic [BUNDLE_W-1:0] r_pipe [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= {i_vld, i_bit, i_addr};
            for (int i = 1; i < int'(STAGES); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {o_vld, o_bit, o_addr} = r_pipe[STAGES-1];

endmodule

// File: rtl/sig_ram_ctrl.sv
// Signature RAM controller: records the serial signature into a 1-bit RAM or
// compares the live stream against it. SIG_RAM_CTRL_FAIL_LOG_EN adds first-failure logging.
module sig_ram_ctrl
    import sig_pkg::*;
#(
    parameter int unsigned ADDR_W = SIG_ADDR_W,
    parameter int unsigned DEPTH  = SIG_DEPTH,
    parameter int unsigned RD_LAT = SIG_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    sig_ram_ctrl_if.slave bus
);

    localparam int unsigned       PIPE_STAGES = RD_LAT + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CNT_MAX     = '1;

    sig_state_e        r_state;
    sig_state_e        w_state_nxt;

    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ADDR_W-1:0] r_mis_cnt;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_d;
    logic              r_ram_wren;
    logic              r_last_seen;

    logic              w_run_st;
    logic              w_start_acc;
    logic              w_proc;
    logic              w_proc_rec;
    logic              w_proc_cmp;
    logic              w_is_last;
    logic              w_pipe_vld;
    logic              w_pipe_bit;
    logic [ADDR_W-1:0] w_pipe_addr;
    logic              w_mismatch;
    logic [ADDR_W-1:0] w_mis_cnt_nxt;

    // Once the last address is taken, further bits are ignored while COMPARE drains.
    assign w_run_st    = (r_state == ST_RECORD) || (r_state == ST_COMPARE);
    assign w_start_acc = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_proc      = w_run_st && bus.cnt_en && (bus.cnt_addr <= LAST_ADDR) && !r_last_seen;
    assign w_proc_rec  = w_proc && (r_state == ST_RECORD);
    assign w_proc_cmp  = w_proc && (r_state == ST_COMPARE);
    assign w_is_last   = (bus.cnt_addr == LAST_ADDR);

    sig_align_pipe #(
        .ADDR_W (ADDR_W),
        .STAGES (PIPE_STAGES)
    ) u_align (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_proc_cmp),
        .i_bit  (bus.sig_bit),
        .i_addr (bus.cnt_addr),
        .o_vld  (w_pipe_vld),
        .o_bit  (w_pipe_bit),
        .o_addr (w_pipe_addr)
    );

    assign w_mismatch = w_pipe_vld && (bus.ram_q != w_pipe_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next mismatch count.
    always_comb begin
        w_state_nxt   = r_state;
        w_mis_cnt_nxt = r_mis_cnt;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_acc) begin
                    w_state_nxt   = (bus.mode == MODE_COMPARE) ? ST_COMPARE : ST_RECORD;
                    w_mis_cnt_nxt = '0;
                end
            end
            ST_RECORD: begin
                if (w_proc && w_is_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_COMPARE: begin
                if (w_mismatch && (r_mis_cnt != CNT_MAX)) begin
                    w_mis_cnt_nxt = r_mis_cnt + ADDR_W'(1);
                end
                if (w_pipe_vld && (w_pipe_addr == LAST_ADDR)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status and RAM port registers, derived from the next state so they track it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_mis_cnt   <= '0;
            r_ram_addr  <= '0;
            r_ram_d     <= 1'b0;
            r_ram_wren  <= 1'b0;
            r_last_seen <= 1'b0;
        end else begin
            r_busy     <= (w_state_nxt == ST_RECORD) || (w_state_nxt == ST_COMPARE);
            r_done     <= (w_state_nxt == ST_DONE);
            r_pass     <= (w_state_nxt == ST_DONE) && (w_mis_cnt_nxt == '0);
            r_mis_cnt  <= w_mis_cnt_nxt;
            r_ram_wren <= w_proc_rec;
            if (w_proc) begin
                r_ram_addr <= bus.cnt_addr;
            end
            if (w_proc_rec) begin
                r_ram_d <= bus.sig_bit;
            end
            if (w_start_acc) begin
                r_last_seen <= 1'b0;
            end else if (w_proc && w_is_last) begin
                r_last_seen <= 1'b1;
            end
        end
    end

    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_d    = r_ram_d;
    assign bus.ram_wren = r_ram_wren;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;
    assign bus.mis_cnt  = r_mis_cnt;

`ifdef SIG_RAM_CTRL_FAIL_LOG_EN
    logic [ADDR_W-1:0] r_fail_addr;
    logic              r_fail_vld;

    // Capture only the first mismatching address of a COMPARE run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fail_addr <= '0;
            r_fail_vld  <= 1'b0;
        end else if (w_start_acc) begin
            r_fail_addr <= '0;
            r_fail_vld  <= 1'b0;
        end else if ((r_state == ST_COMPARE) && w_mismatch && !r_fail_vld) begin
            r_fail_addr <= w_pipe_addr;
            r_fail_vld  <= 1'b1;
        end
    end

    assign bus.fail_addr = r_fail_addr;
    assign bus.fail_vld  = r_fail_vld;
`endif

endmodule

// File: tb/tb_sig_ram_ctrl.sv
// Scoreboard bench for sig_ram_ctrl with a behavioural RAM and a golden-bit reference model.
module tb_sig_ram_ctrl;

    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned RD_LAT  = 1;
    localparam int          TIMEOUT = 40;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              d;
    } wr_t;

    typedef struct packed {
        logic [ADDR_W-1:0] mis;
        logic              pass;
        logic [ADDR_W-1:0] faddr;
        logic              fvld;
    } res_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sig_ram_ctrl_if #(.ADDR_W(ADDR_W)) bus_if ();

    sig_ram_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Behavioural 1-bit RAM with a single registered read stage.
    logic ram_mem [0:31];
    always @(posedge clk) begin
        if (bus_if.ram_wren && (bus_if.ram_addr < 32)) ram_mem[bus_if.ram_addr[4:0]] <= bus_if.ram_d;
        bus_if.ram_q <= (bus_if.ram_addr < 32) ? ram_mem[bus_if.ram_addr[4:0]] : 1'b0;
    end

    wr_t  wr_q  [$];
    res_t res_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_writes = 0;
    logic golden [0:DEPTH-1];
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes and run results as the DUT presents them.
    always @(negedge clk) begin
        wr_t  ew;
        res_t er;
        if (!rst) begin
            if (bus_if.ram_wren) begin
                n_writes++;
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'(bus_if.ram_addr), 32'hFFFF_FFFF);
                end else begin
                    ew = wr_q.pop_front();
                    check("wr_addr", 32'(bus_if.ram_addr), 32'(ew.addr));
                    check("wr_data", 32'(bus_if.ram_d), 32'(ew.d));
                end
            end
            if (bus_if.done && !prev_done) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 32'(bus_if.done), 32'd0);
                end else begin
                    er = res_q.pop_front();
                    check("mis_cnt", 32'(bus_if.mis_cnt), 32'(er.mis));
                    check("pass", 32'(bus_if.pass), 32'(er.pass));
                    check("busy_at_done", 32'(bus_if.busy), 32'd0);
`ifdef SIG_RAM_CTRL_FAIL_LOG_EN
                    check("fail_addr", 32'(bus_if.fail_addr), 32'(er.faddr));
                    check("fail_vld", 32'(bus_if.fail_vld), 32'(er.fvld));
`endif
                end
            end
            prev_done <= bus_if.done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic drive(input logic st, input logic md, input logic en,
                         input logic [ADDR_W-1:0] a, input logic b);
        @(posedge clk);
        #1;
        bus_if.start    = st;
        bus_if.mode     = md;
        bus_if.cnt_en   = en;
        bus_if.cnt_addr = a;
        bus_if.sig_bit  = b;
    endtask

    // One run. Negative position arguments disable that disturbance.
    task automatic do_run(input logic md, input logic [0:DEPTH-1] bits,
                          input int gap_at, input int gap_len, input int junk_at,
                          input int start_at, input int rst_at);
        res_t r;
        int   mis  = 0;
        int   cyc  = 0;
        logic fv   = 1'b0;
        int   fa   = 0;
        if (md == 1'b1) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (golden[i] != bits[i]) begin
                    if (!fv) fa = i;
                    fv = 1'b1;
                    mis++;
                end
            end
        end else begin
            // A write lands one edge after its bit; a reset on the next bit kills it.
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (rst_at < 0 || i < rst_at - 1) golden[i] = bits[i];
            end
        end
        r.mis   = ADDR_W'(mis);
        r.pass  = (mis == 0);
        r.faddr = ADDR_W'(fa);
        r.fvld  = fv;
        res_q.push_back(r);
        n_writes = 0;

        drive(1'b1, md, 1'b0, '0, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == gap_at) begin
                repeat (gap_len) begin
                    drive(1'b0, md, 1'b0, ADDR_W'(i), bits[i]);
                    check("busy_in_pause", 32'(bus_if.busy), 32'd1);
                    check("done_in_pause", 32'(bus_if.done), 32'd0);
                end
            end
            if (i == junk_at) drive(1'b0, md, 1'b1, ADDR_W'(9), ~golden[1]);
            if (i == rst_at) begin
                @(posedge clk);
                #1;
                rst = 1'b1;
                bus_if.cnt_en = 1'b0;
                #1;
                check("rst_wren", 32'(bus_if.ram_wren), 32'd0);
                check("rst_busy", 32'(bus_if.busy), 32'd0);
                check("rst_done", 32'(bus_if.done), 32'd0);
                check("rst_ram_addr", 32'(bus_if.ram_addr), 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                wr_q.delete();
                void'(res_q.pop_back());
                return;
            end
            if (md == 1'b0) wr_q.push_back('{addr: ADDR_W'(i), d: bits[i]});
            drive(i == start_at, ~md, 1'b1, ADDR_W'(i), bits[i]);
        end
        drive(1'b0, md, 1'b0, '0, 1'b0);
        while (!bus_if.done && cyc < TIMEOUT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_reached", 32'(bus_if.done), 32'd1);
        @(posedge clk);
        #1;
        check("writes_drained", 32'(wr_q.size()), 32'd0);
        check("write_count", 32'(n_writes), (md == 1'b0) ? 32'(DEPTH) : 32'd0);
    endtask

    initial begin
        logic [0:DEPTH-1] s;
        logic [0:DEPTH-1] flip;
        logic [0:DEPTH-1] rb;
        logic             md;
        int               g;
        s    = 8'b10110010;
        flip = 8'b00010100;
        for (int i = 0; i < int'(DEPTH); i++) golden[i] = 1'b0;

        rst             = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.mode     = 1'b0;
        bus_if.cnt_en   = 1'b0;
        bus_if.cnt_addr = '0;
        bus_if.sig_bit  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_done", 32'(bus_if.done), 32'd0);
        check("reset_pass", 32'(bus_if.pass), 32'd0);
        check("reset_mis_cnt", 32'(bus_if.mis_cnt), 32'd0);
        check("reset_wren", 32'(bus_if.ram_wren), 32'd0);
        check("reset_ram_addr", 32'(bus_if.ram_addr), 32'd0);
        check("reset_ram_d", 32'(bus_if.ram_d), 32'd0);

        // Out-of-range addresses while idle must not write.
        n_writes = 0;
        for (int a = 8; a <= 12; a++) drive(1'b0, 1'b0, 1'b1, ADDR_W'(a), 1'b1);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        check("idle_junk_writes", 32'(n_writes), 32'd0);
        check("idle_junk_busy", 32'(bus_if.busy), 32'd0);

        do_run(1'b0, s,        -1, 0,  2, -1, -1);
        do_run(1'b1, s,        -1, 0, -1, -1, -1);
        do_run(1'b1, s ^ flip, -1, 0,  6, -1, -1);
        do_run(1'b0, s,         4, 3, -1, -1, -1);
        do_run(1'b0, 8'b01011100, -1, 0, -1, -1, 5);
        check("post_abort_busy", 32'(bus_if.busy), 32'd0);
        check("post_abort_mis", 32'(bus_if.mis_cnt), 32'd0);
        do_run(1'b0, s,        -1, 0, -1, -1, -1);
        do_run(1'b1, s ^ flip, -1, 0, -1,  2, -1);

        for (int k = 0; k < 8; k++) begin
            rb = DEPTH'($urandom());
            md = 1'($urandom_range(0, 1));
            g  = (($urandom_range(0, 1)) == 1) ? int'($urandom_range(0, DEPTH - 1)) : -1;
            do_run(md, rb, g, int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 2 * DEPTH)) - int'(DEPTH), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
